seg7_scan_decoder: RTL and testbench
====================================

// Module: seg7_scan_decoder
// PURPOSE
//   Reverse of the BCD/hex-to-7-segment decoder: monitors a multiplexed 7-segment display bus
//   (segments a..g, dp, plus one-hot digit enables).
//   Checks that each digit's pattern is stable, then decodes it back to a 4-bit hex value.
//   Delivers one complete display frame per valid/ready handshake.
//   Sits between the display pins (or a display driver under test) and downstream checker/logging logic.
// PARAMETERS
//   NUM_DIGITS   4   number of multiplexed digits; width of dig_en and of per-digit output fields
//   STABLE_CYC   8   consecutive identical samples required before a digit is captured (>=2)
// PORTS
//   clk          input   1               system clock, single clock domain
//   rst_n        input   1               asynchronous, active-low reset
//   seg_in       input   8               {dp,g,f,e,d,c,b,a}, active-high, asynchronous to clk
//   dig_en       input   NUM_DIGITS      digit enables, active-high, expected one-hot, asynchronous
//   out_ready    input   1               downstream accepts frame when high with out_valid
//   out_valid    output  1               frame available on out_* fields
//   out_digits   output  4*NUM_DIGITS    decoded hex value per digit, digit i at [4i+3:4i]
//   out_dp       output  NUM_DIGITS      captured dp bit per digit
//   out_err      output  NUM_DIGITS      1 = digit pattern not in decode table (its out_digits field = 0)
//   overflow     output  1               sticky: a completed frame was dropped while out_valid && !out_ready
// BEHAVIOUR
//   Reset: out_valid, out_digits, out_dp, out_err, overflow = 0; seen mask, stability counter, sync regs = 0.
//   Sync: {dig_en,seg_in} pass through a 2-flop synchronizer; all logic below uses the synced value S.
//   Stability: counter cnt cleared when S != S of previous cycle.
//     Otherwise cnt increments, saturating at STABLE_CYC.
//     Capture fires on exactly the cycle cnt goes STABLE_CYC-1 -> STABLE_CYC (once per stable period).
//   Capture suppressed if dig_en part of S is zero or not one-hot; counter behaviour unchanged.
//   Capture into slot i (the set bit of dig_en):
//     - decode seg[6:0] using the hex table 0..F =
//       3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71;
//     - a miss gives err=1, value=0; dp stored as-is;
//     - set seen[i]; recapturing the same slot within a frame overwrites it.
//   Frame FSM: COLLECT -> (seen all ones) frame complete, evaluated the cycle after the last capture.
//     - out_valid=0, or out_valid=1 with out_ready=1 in that cycle:
//       load out_* and set out_valid=1 next cycle; a back-to-back handoff keeps out_valid high with new data.
//     - out_valid=1 with out_ready=0: drop the frame and set overflow (sticky until reset).
//     - In all cases clear seen and return to COLLECT.
//   Handshake: out_* held constant while out_valid && !out_ready.
//     out_valid falls the cycle after acceptance unless a new frame loads.
//   Latency: pin change to capture = 2 (sync) + STABLE_CYC cycles.
//     Capture of the last digit to out_valid = 2 cycles.
//   Reset mid-frame: partial frame and pending output discarded; no spurious out_valid after release.
//   Glitch shorter than STABLE_CYC samples: never captured, and it restarts the stability count.
// STRUCTURE
//   Shared package/header: SEG_* constant table (16 patterns), segment bit-order constants,
//     FSM state encodings.
//   Sub-module seg7_to_hex: combinational pattern -> {err,value[3:0]} lookup, shared with the
//     display-driver bench checkers.
//   Top: synchronizer, stability counter, one-hot check, slot registers, frame FSM, output regs.
// TESTING
//   1. Drive digits 0..3 = patterns 06,5B,4F,66, 20 cycles each, out_ready=1
//      -> one frame, out_digits=16'h4321, out_err=0, out_dp=0.
//   2. Digit2 pattern 0x49 (invalid) with dp=1, others valid
//      -> out_err=4'b0100, out_dp=4'b0100, digit2 field=0.
//   3. Pattern toggles every 3 cycles (STABLE_CYC=8) -> no capture, out_valid stays 0.
//   4. Hold out_ready=0 across two completed frames
//      -> first frame held unchanged, overflow=1 after second, data unchanged.
//   5. dig_en=4'b0011 stable 20 cycles -> no capture.
//      dig_en=0 -> no capture; seen unchanged.
//   6. Assert rst_n=0 after 3 of 4 digits captured; release, capture the 4th only
//      -> no out_valid until all 4 recaptured.

Source files
------------

// File: rtl/seg7_scan_decoder_pkg.sv
// Shared constants for the 7-segment scan decoder: segment bit order, the hex
// pattern table and the output-stage state encoding.
package seg7_scan_decoder_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;
  localparam int SEG_W  = 8;

  // Entry k is the {g,f,e,d,c,b,a} pattern that displays hex digit k.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  typedef struct packed {
    logic       err;
    logic [3:0] value;
  } hex_dec_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational 7-segment pattern to hex lookup; unknown patterns report err
// with a zero value.
module seg7_to_hex
  import seg7_scan_decoder_pkg::*;
(
  input  logic [6:0] pattern,
  output hex_dec_t   dec
);

  always_comb begin
    dec = '{err: 1'b1, value: 4'h0};
    for (int k = 0; k < 16; k++) begin
      if (pattern == SEG_TABLE[k]) begin
        dec.err   = 1'b0;
        dec.value = 4'(k);
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Monitors a multiplexed 7-segment bus, captures each digit once it has been
// stable, decodes it back to hex and hands out complete frames via valid/ready.
module seg7_scan_decoder
  import seg7_scan_decoder_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CYC = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [4*NUM_DIGITS-1:0] out_digits,
  output logic [NUM_DIGITS-1:0]   out_dp,
  output logic [NUM_DIGITS-1:0]   out_err,
  output logic                    overflow
);

  localparam int SW = NUM_DIGITS + SEG_W;
  localparam int CW = $clog2(STABLE_CYC + 1);

  logic [SW-1:0]         sync1_reg, samp_reg, prev_reg;
  logic [CW-1:0]         cnt_reg;
  logic [NUM_DIGITS-1:0] samp_dig;
  logic [7:0]            samp_seg;
  logic                  stable, onehot, capture;
  hex_dec_t              dec;

  assign {samp_dig, samp_seg} = samp_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      samp_reg  <= '0;
      prev_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= {dig_en, seg_in};
      samp_reg  <= sync1_reg;
      prev_reg  <= samp_reg;
      if (!stable)
        cnt_reg <= '0;
      else if (cnt_reg != CW'(STABLE_CYC))
        cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign stable  = (samp_reg == prev_reg);
  assign onehot  = (samp_dig != '0) &&
                   ((samp_dig & (samp_dig - NUM_DIGITS'(1))) == '0);
  // Fires once per stable period, on the step into saturation.
  assign capture = stable && (cnt_reg == CW'(STABLE_CYC - 1)) && onehot;

  seg7_to_hex u_dec (
    .pattern (samp_seg[6:0]),
    .dec     (dec)
  );

  logic [NUM_DIGITS-1:0]   cap_slot, seen_reg, slot_dp, slot_err;
  logic [3:0]              slot_val [NUM_DIGITS];
  logic [4*NUM_DIGITS-1:0] frame_digits;
  logic                    frame_done;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
    assign cap_slot[gi]             = capture && samp_dig[gi];
    assign frame_digits[4*gi +: 4]  = slot_val[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) slot_val[i] <= 4'h0;
      slot_dp  <= '0;
      slot_err <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (cap_slot[i]) begin
          slot_val[i] <= dec.value;
          slot_dp[i]  <= samp_seg[SEG_DP];
          slot_err[i] <= dec.err;
        end
      end
    end
  end

  assign frame_done = (seen_reg == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      seen_reg <= '0;
    else if (frame_done)
      seen_reg <= cap_slot;
    else
      seen_reg <= seen_reg | cap_slot;
  end

  out_state_t state_reg, state_next;
  logic       load, drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= OUT_EMPTY;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    drop       = 1'b0;
    case (state_reg)
      OUT_EMPTY: begin
        if (frame_done) begin
          load       = 1'b1;
          state_next = OUT_FULL;
        end
      end
      OUT_FULL: begin
        if (frame_done) begin
          if (out_ready) load = 1'b1;
          else           drop = 1'b1;
        end else if (out_ready) begin
          state_next = OUT_EMPTY;
        end
      end
      default: state_next = OUT_EMPTY;
    endcase
  end

  logic [4*NUM_DIGITS-1:0] out_digits_reg;
  logic [NUM_DIGITS-1:0]   out_dp_reg, out_err_reg;
  logic                    overflow_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_digits_reg <= '0;
      out_dp_reg     <= '0;
      out_err_reg    <= '0;
      overflow_reg   <= 1'b0;
    end else begin
      if (load) begin
        out_digits_reg <= frame_digits;
        out_dp_reg     <= slot_dp;
        out_err_reg    <= slot_err;
      end
      if (drop) overflow_reg <= 1'b1;
    end
  end

  assign out_valid  = (state_reg == OUT_FULL);
  assign out_digits = out_digits_reg;
  assign out_dp     = out_dp_reg;
  assign out_err    = out_err_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench: stimulus pushes expected frames from a digit-level model,
// a monitor compares every presented frame against the queue head.
module tb_seg7_scan_decoder;

  localparam int ND      = 4;
  localparam int SC      = 8;
  localparam int CAP_MIN = 14;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  seg_in = 8'h00;
  logic [3:0]  dig_en = 4'h0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [15:0] out_digits;
  logic [3:0]  out_dp, out_err;
  logic        overflow;

  seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYC(SC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_in     (seg_in),
    .dig_en     (dig_en),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_digits (out_digits),
    .out_dp     (out_dp),
    .out_err    (out_err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  err;
  } frame_t;

  frame_t     exp_q[$];
  int         n_vec = 0;
  int         n_bad = 0;
  int         ready_mode = 1;
  logic       hold_mode = 1'b0;
  logic       exp_ovf = 1'b0;
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [3:0] m_val [ND];
  logic [3:0] m_dp = 4'h0, m_err = 4'h0, m_seen = 4'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] decode(input logic [7:0] s);
    for (int k = 0; k < 16; k++)
      if (seg_tab[k] == s[6:0]) return {1'b0, 4'(k)};
    return 5'h10;
  endfunction

  task automatic frame_complete();
    frame_t f;
    f.digits = {m_val[3], m_val[2], m_val[1], m_val[0]};
    f.dp     = m_dp;
    f.err    = m_err;
    if (hold_mode && exp_q.size() > 0) exp_ovf = 1'b1;
    else                               exp_q.push_back(f);
    m_seen = 4'h0;
  endtask

  task automatic drive(input logic [3:0] d, input logic [7:0] s, input int n);
    dig_en = d;
    seg_in = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Long enough holds are captured; the model updates before the DUT can respond.
  task automatic show(input int d, input logic [7:0] s, input int n);
    logic [4:0] r;
    if (n >= CAP_MIN) begin
      r         = decode(s);
      m_val[d]  = r[3:0];
      m_err[d]  = r[4];
      m_dp[d]   = s[7];
      m_seen[d] = 1'b1;
      if (m_seen == 4'hF) frame_complete();
    end
    drive(4'(1 << d), s, n);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (6) @(posedge clk);
    #1;
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic apply_reset();
    rst_n  = 1'b0;
    dig_en = 4'h0;
    seg_in = 8'h00;
    exp_q.delete();
    m_seen  = 4'h0;
    exp_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'({out_valid, overflow, out_digits, out_dp, out_err}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 4) != 0);
    endcase
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 32'(out_valid), 32'd0);
      end else begin
        check("frame", 32'({out_digits, out_dp, out_err}), 32'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int prev_d;
    int d;
    logic [7:0] s;
    for (int i = 0; i < ND; i++) m_val[i] = 4'h0;
    apply_reset();

    // Plain frame 4321
    ready_mode = 1;
    show(0, 8'h06, 20); show(1, 8'h5B, 20); show(2, 8'h4F, 20); show(3, 8'h66, 20);
    drain("t1_drain");

    // Invalid pattern with dp on digit 2
    show(0, 8'h7D, 20); show(1, 8'h07, 20); show(2, 8'hC9, 20); show(3, 8'h6F, 20);
    drain("t2_drain");

    // Fast toggling on the last missing digit never completes the frame
    show(1, 8'h66, 20); show(2, 8'h6D, 20); show(3, 8'h7F, 20);
    for (int i = 0; i < 12; i++) show(0, (i % 2 == 0) ? 8'h06 : 8'h5B, 3);
    check("t3_no_frame", 32'(out_valid), 32'd0);
    show(0, 8'h77, 20);
    drain("t3_drain");

    // Two frames while out_ready is low: first held, second dropped
    ready_mode = 0;
    hold_mode  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    show(0, 8'h3F, 16); show(1, 8'h06, 16); show(2, 8'h5B, 16); show(3, 8'h4F, 16);
    show(0, 8'h39, 16); show(1, 8'h5E, 16); show(2, 8'h79, 16); show(3, 8'h71, 16);
    repeat (5) @(posedge clk);
    #1;
    check("t4_overflow", 32'(overflow), 32'(exp_ovf));
    check("t4_pending", 32'(exp_q.size()), 32'd1);
    ready_mode = 1;
    hold_mode  = 1'b0;
    drain("t4_drain");
    check("t4_overflow_sticky", 32'(overflow), 32'd1);

    // Non-one-hot and empty enables are ignored and leave seen intact
    show(0, 8'h7C, 20); show(1, 8'h07, 20); show(2, 8'h86, 20);
    drive(4'b0011, 8'h5B, 20);
    drive(4'b0000, 8'h06, 20);
    drive(4'b1100, 8'h66, 20);
    check("t5_no_frame", 32'(out_valid), 32'd0);
    show(3, 8'h79, 20);
    drain("t5_drain");

    // Reset after three captures discards the partial frame
    show(0, 8'h06, 20); show(1, 8'h5B, 20); show(2, 8'h4F, 20);
    repeat (3) @(posedge clk);
    #1;
    apply_reset();
    show(3, 8'h66, 20);
    repeat (10) @(posedge clk);
    #1;
    check("t6_no_frame", 32'(out_valid), 32'd0);
    show(0, 8'h6D, 20); show(1, 8'h7D, 20); show(2, 8'h07, 20);
    drain("t6_drain");

    // Random digits, patterns, glitches and backpressure
    ready_mode = 2;
    prev_d = 0;
    for (int i = 0; i < 60; i++) begin
      do d = $urandom_range(0, ND - 1); while (d == prev_d);
      prev_d = d;
      if ($urandom_range(0, 3) == 0) s = 8'($urandom_range(0, 255));
      else s = {1'($urandom_range(0, 1)), seg_tab[$urandom_range(0, 15)]};
      if ($urandom_range(0, 3) == 0)
        drive(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), $urandom_range(1, 4));
      show(d, s, $urandom_range(CAP_MIN, 24));
    end
    ready_mode = 1;
    drain("t7_drain");
    check("t7_overflow", 32'(overflow), 32'(exp_ovf));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
